// File: rtl/bcd_multi_digit_counter.sv
// Parametrised multi-digit BCD up/down counter with validated parallel load,
// wrap-or-saturate limit handling and a combinational carry-out for cascading.
module bcd_multi_digit_counter #(
  parameter int unsigned DIGITS = 2,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  ovf,
  output logic                  load_err
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] q_q, q_d, q_step;
  logic         ovf_q, ovf_d;
  logic         load_err_q, load_err_d;
  logic         all_nine, all_zero, load_ok, limit, chain;

  always_comb begin
    all_nine = 1'b1;
    all_zero = 1'b1;
    load_ok  = 1'b1;
    q_step   = q_q;
    chain    = 1'b1;

    // Ripple the carry/borrow from digit 0; a digit steps only while every lower digit rolled over.
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (q_q[4*i +: 4] != 4'd9) all_nine = 1'b0;
      if (q_q[4*i +: 4] != 4'd0) all_zero = 1'b0;
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
      if (chain) begin
        if (up) begin
          if (q_q[4*i +: 4] == 4'd9) begin
            q_step[4*i +: 4] = 4'd0;
          end else begin
            q_step[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
            chain = 1'b0;
          end
        end else begin
          if (q_q[4*i +: 4] == 4'd0) begin
            q_step[4*i +: 4] = 4'd9;
          end else begin
            q_step[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
            chain = 1'b0;
          end
        end
      end
    end

    limit = (up & all_nine) | (~up & all_zero);
    tc    = en & ~load & limit;

    q_d        = q_q;
    ovf_d      = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) q_d = load_val;
      else         load_err_d = 1'b1;
    end else if (en) begin
      ovf_d = limit;
      if (!limit || WRAP) q_d = q_step;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q        <= '0;
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = q_q;
  assign ovf      = ovf_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_multi_digit_counter.sv
// Directed bench: a wrapping and a saturating 2-digit instance share one stimulus stream.
module tb_bcd_multi_digit_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] q_w, q_s;
  logic       tc_w, tc_s, ovf_w, ovf_s, err_w, err_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_multi_digit_counter #(.DIGITS(2), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q_w), .tc(tc_w), .ovf(ovf_w), .load_err(err_w)
  );

  bcd_multi_digit_counter #(.DIGITS(2), .WRAP(1'b0)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q_s), .tc(tc_s), .ovf(ovf_s), .load_err(err_s)
  );

  typedef struct {
    bit         rst, en, up, ld;
    logic [7:0] lv;
    bit         chk_tc;
    logic       tc_w, tc_s;
    logic [7:0] q_w;
    logic       ovf_w;
    logic [7:0] q_s;
    logic       ovf_s;
    logic       err;
  } vec_t;

  function automatic vec_t mk(bit r, bit e, bit u, bit l, logic [7:0] lv, bit ct,
                              logic tw, logic ts, logic [7:0] qw, logic ow,
                              logic [7:0] qs, logic os, logic er);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.ld = l; v.lv = lv; v.chk_tc = ct;
    v.tc_w = tw; v.tc_s = ts; v.q_w = qw; v.ovf_w = ow; v.q_s = qs; v.ovf_s = os; v.err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, check tc before the rising edge, registered outputs after it.
  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clk);
    reset = v.rst; en = v.en; up = v.up; load = v.ld; load_val = v.lv;
    #1;
    if (v.chk_tc) begin
      chk({tag, " tc_w"}, {7'd0, tc_w}, {7'd0, v.tc_w});
      chk({tag, " tc_s"}, {7'd0, tc_s}, {7'd0, v.tc_s});
    end
    @(posedge clk);
    #1;
    chk({tag, " q_w"},   q_w,                {v.q_w});
    chk({tag, " ovf_w"}, {7'd0, ovf_w},      {7'd0, v.ovf_w});
    chk({tag, " err_w"}, {7'd0, err_w},      {7'd0, v.err});
    chk({tag, " q_s"},   q_s,                {v.q_s});
    chk({tag, " ovf_s"}, {7'd0, ovf_s},      {7'd0, v.ovf_s});
    chk({tag, " err_s"}, {7'd0, err_s},      {7'd0, v.err});
  endtask

  vec_t tbl[$];

  initial begin
    // rst en up ld lv   ctc tcw tcs  qw  ow  qs  os  err
    tbl.push_back(mk(1,1,1,0,8'h00, 0,0,0, 8'h00,0, 8'h00,0, 0));
    tbl.push_back(mk(1,1,1,0,8'h00, 1,0,0, 8'h00,0, 8'h00,0, 0));
    tbl.push_back(mk(0,1,1,0,8'h00, 1,0,0, 8'h01,0, 8'h01,0, 0));
    tbl.push_back(mk(0,1,1,0,8'h00, 1,0,0, 8'h02,0, 8'h02,0, 0));
    tbl.push_back(mk(0,0,1,1,8'h07, 1,0,0, 8'h07,0, 8'h07,0, 0));
    tbl.push_back(mk(0,1,1,0,8'h00, 1,0,0, 8'h08,0, 8'h08,0, 0));
    tbl.push_back(mk(0,1,1,0,8'h00, 1,0,0, 8'h09,0, 8'h09,0, 0));
    tbl.push_back(mk(0,1,1,0,8'h00, 1,0,0, 8'h10,0, 8'h10,0, 0));
    tbl.push_back(mk(0,1,1,0,8'h00, 1,0,0, 8'h11,0, 8'h11,0, 0));
    tbl.push_back(mk(0,1,1,0,8'h00, 1,0,0, 8'h12,0, 8'h12,0, 0));
    tbl.push_back(mk(0,0,1,1,8'h25, 1,0,0, 8'h25,0, 8'h25,0, 0));
    tbl.push_back(mk(0,1,1,1,8'h3A, 1,0,0, 8'h25,0, 8'h25,0, 1));
    tbl.push_back(mk(0,1,1,1,8'h42, 1,0,0, 8'h42,0, 8'h42,0, 0));
    tbl.push_back(mk(0,0,1,0,8'h00, 1,0,0, 8'h42,0, 8'h42,0, 0));
    tbl.push_back(mk(0,0,1,1,8'h56, 1,0,0, 8'h56,0, 8'h56,0, 0));
    tbl.push_back(mk(0,1,1,0,8'h00, 1,0,0, 8'h57,0, 8'h57,0, 0));
    tbl.push_back(mk(1,1,1,1,8'h33, 1,0,0, 8'h00,0, 8'h00,0, 0));
    tbl.push_back(mk(0,0,0,1,8'h20, 1,0,0, 8'h20,0, 8'h20,0, 0));
    tbl.push_back(mk(0,1,0,0,8'h00, 1,0,0, 8'h19,0, 8'h19,0, 0));
    tbl.push_back(mk(0,1,0,0,8'h00, 1,0,0, 8'h18,0, 8'h18,0, 0));
    tbl.push_back(mk(0,0,0,1,8'h10, 1,0,0, 8'h10,0, 8'h10,0, 0));
    tbl.push_back(mk(0,1,0,0,8'h00, 1,0,0, 8'h09,0, 8'h09,0, 0));
    tbl.push_back(mk(0,0,0,1,8'hA0, 1,0,0, 8'h09,0, 8'h09,0, 1));
    tbl.push_back(mk(0,0,0,0,8'h00, 1,0,0, 8'h09,0, 8'h09,0, 0));

    for (int i = 0; i < tbl.size(); i++)
      run_vec($sformatf("vec%0d", i), tbl[i]);

    // Up through 99: wrap rolls to 00, saturate holds and keeps pulsing ovf.
    run_vec("up_ld98", mk(0,0,1,1,8'h98, 1,0,0, 8'h98,0, 8'h98,0, 0));
    run_vec("up_s1",   mk(0,1,1,0,8'h00, 1,0,0, 8'h99,0, 8'h99,0, 0));
    run_vec("up_s2",   mk(0,1,1,0,8'h00, 1,1,1, 8'h00,1, 8'h99,1, 0));
    run_vec("up_s3",   mk(0,1,1,0,8'h00, 1,0,1, 8'h01,0, 8'h99,1, 0));
    run_vec("up_idle", mk(0,0,1,0,8'h00, 1,0,0, 8'h01,0, 8'h99,0, 0));

    // Down through 00.
    run_vec("dn_ld00", mk(0,0,0,1,8'h00, 1,0,0, 8'h00,0, 8'h00,0, 0));
    run_vec("dn_s1",   mk(0,1,0,0,8'h00, 1,1,1, 8'h99,1, 8'h00,1, 0));
    run_vec("dn_idle", mk(0,0,0,0,8'h00, 1,0,0, 8'h99,0, 8'h00,0, 0));

    // Down from 01 for four cycles.
    run_vec("sat_ld01", mk(0,0,0,1,8'h01, 1,0,0, 8'h01,0, 8'h01,0, 0));
    run_vec("sat_s1",   mk(0,1,0,0,8'h00, 1,0,0, 8'h00,0, 8'h00,0, 0));
    run_vec("sat_s2",   mk(0,1,0,0,8'h00, 1,1,1, 8'h99,1, 8'h00,1, 0));
    run_vec("sat_s3",   mk(0,1,0,0,8'h00, 1,0,1, 8'h98,0, 8'h00,1, 0));
    run_vec("sat_s4",   mk(0,1,0,0,8'h00, 1,0,1, 8'h97,0, 8'h00,1, 0));

    // Load at the limit suppresses tc and ovf.
    run_vec("ld_at_lim", mk(0,1,0,1,8'h55, 1,0,0, 8'h55,0, 8'h55,0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
